// File: rtl/inv_key_schedule.sv
// -----------------------------------------------------------------------------
// inv_key_schedule
//
// On-the-fly AES-128 inverse key schedule. Starting from the final round key
// K10, the block walks the key schedule backwards and presents K10, K9 ... K0,
// one round key per valid/ready handshake. Only the current round key is
// stored. All SubWord lookups go through an external, combinational, shared
// S-box word port.
//
// Optional feature (compile-time macro INV_KEY_FWD_EXPAND_EN):
//   When defined, key_i is the cipher key K0. An EXPAND phase first runs the
//   ten forward key-expansion steps (one per cycle) to reach K10, after which
//   the backward walk proceeds as usual. When undefined, key_i must be K10
//   and neither the EXPAND state nor its step counter exist.
//
// Ports:
//   clk_i        in   1    clock, rising edge
//   rst_ni       in   1    asynchronous active-low reset
//   start_i      in   1    start a run (sampled only in IDLE)
//   key_i        in   128  K10 (or K0 with INV_KEY_FWD_EXPAND_EN)
//   W_S_box      in   32   byte-wise SubWord of sbox_word_o (combinational)
//   sbox_word_o  out  32   word presented to the external S-box
//   key_o        out  128  current round key {w0,w1,w2,w3}, w0 in [127:96]
//   round_o      out  4    round index of key_o (10 down to 0)
//   key_valid_o  out  1    key_o is valid
//   key_ready_i  in   1    consumer accepts key_o
//   done_o       out  1    one-cycle pulse after K0 is accepted
// -----------------------------------------------------------------------------
`ifndef KEY_WIDTH
`define KEY_WIDTH 128
`endif
`ifndef FOUR_BYTE_WIDTH
`define FOUR_BYTE_WIDTH 32
`endif
`ifndef BYTE_WIDTH
`define BYTE_WIDTH 8
`endif

module inv_key_schedule (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic [`KEY_WIDTH-1:0]       key_i,
    input  logic [`FOUR_BYTE_WIDTH-1:0] W_S_box,
    output logic [`FOUR_BYTE_WIDTH-1:0] sbox_word_o,
    output logic [`KEY_WIDTH-1:0]       key_o,
    output logic [3:0]                  round_o,
    output logic                        key_valid_o,
    input  logic                        key_ready_i,
    output logic                        done_o
);

    localparam int unsigned WW = `FOUR_BYTE_WIDTH;
    localparam int unsigned BW = `BYTE_WIDTH;

    localparam logic [3:0]    ROUND_LAST = 4'd10;
    localparam logic [BW-1:0] RC_K10     = 8'h36;

`ifdef INV_KEY_FWD_EXPAND_EN
    localparam logic [BW-1:0] RC_K1      = 8'h01;
    localparam logic [3:0]    STEP_LAST  = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd2
    } state_e;
`endif

    // RotWord: cyclic left rotation of a word by one byte.
    function automatic logic [WW-1:0] rot_word(input logic [WW-1:0] w);
        return {w[WW-BW-1:0], w[WW-1:WW-BW]};
    endfunction

    // Backward round-constant step: multiply by x^-1 in GF(2^8).
    function automatic logic [BW-1:0] rcon_inv_step(input logic [BW-1:0] rc);
        return (rc >> 1) ^ (rc[0] ? 8'h8d : 8'h00);
    endfunction

`ifdef INV_KEY_FWD_EXPAND_EN
    // Forward round-constant step: multiply by x in GF(2^8).
    function automatic logic [BW-1:0] rcon_fwd_step(input logic [BW-1:0] rc);
        return (rc << 1) ^ (rc[BW-1] ? 8'h1b : 8'h00);
    endfunction
`endif

    state_e               state_q, state_d;
    logic [`KEY_WIDTH-1:0] key_q, key_d;
    logic [3:0]           round_q, round_d;
    logic [BW-1:0]        rc_q, rc_d;
    logic                 key_valid_q, key_valid_d;
    logic                 done_q, done_d;
`ifdef INV_KEY_FWD_EXPAND_EN
    logic [3:0]           step_q, step_d;
`endif

    logic [WW-1:0] w0_s, w1_s, w2_s, w3_s;
    logic [WW-1:0] sub_rot_s;
    logic [WW-1:0] rc_word_s;
    logic [WW-1:0] inv_t_s;
    logic [`KEY_WIDTH-1:0] inv_key_s;
`ifdef INV_KEY_FWD_EXPAND_EN
    logic [WW-1:0] fw0_s, fw1_s, fw2_s, fw3_s;
    logic [`KEY_WIDTH-1:0] fwd_key_s;
`endif

    // Split the current key into words and build the forward/backward step.
    always_comb begin
        w0_s      = key_q[4*WW-1:3*WW];
        w1_s      = key_q[3*WW-1:2*WW];
        w2_s      = key_q[2*WW-1:WW];
        w3_s      = key_q[WW-1:0];
        // The S-box is byte-wise, so SubWord(RotWord(x)) == RotWord(SubWord(x)).
        sub_rot_s = rot_word(W_S_box);
        rc_word_s = {rc_q, {(WW-BW){1'b0}}};
        // Old w3 is recovered as w3'^w2'; it is the word fed to the S-box.
        inv_t_s   = w3_s ^ w2_s;
        inv_key_s = {w0_s ^ sub_rot_s ^ rc_word_s,
                     w1_s ^ w0_s,
                     w2_s ^ w1_s,
                     inv_t_s};
`ifdef INV_KEY_FWD_EXPAND_EN
        fw0_s     = w0_s ^ sub_rot_s ^ rc_word_s;
        fw1_s     = w1_s ^ fw0_s;
        fw2_s     = w2_s ^ fw1_s;
        fw3_s     = w3_s ^ fw2_s;
        fwd_key_s = {fw0_s, fw1_s, fw2_s, fw3_s};
`endif
    end

    // Select the word presented to the shared S-box.
    always_comb begin
`ifdef INV_KEY_FWD_EXPAND_EN
        if (state_q == ST_EXPAND) begin
            sbox_word_o = w3_s;
        end else begin
            sbox_word_o = inv_t_s;
        end
`else
        sbox_word_o = inv_t_s;
`endif
    end

    // Next-state, next-key and handshake logic.
    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        round_d  = round_q;
        rc_d     = rc_q;
        done_d   = 1'b0;
`ifdef INV_KEY_FWD_EXPAND_EN
        step_d   = step_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    key_d   = key_i;
`ifdef INV_KEY_FWD_EXPAND_EN
                    state_d = ST_EXPAND;
                    rc_d    = RC_K1;
                    step_d  = 4'd0;
`else
                    state_d = ST_ACTIVE;
                    round_d = ROUND_LAST;
                    rc_d    = RC_K10;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end

`ifdef INV_KEY_FWD_EXPAND_EN
            ST_EXPAND: begin
                key_d  = fwd_key_s;
                rc_d   = rcon_fwd_step(rc_q);
                step_d = step_q + 4'd1;
                if (step_q == STEP_LAST) begin
                    // K10 is now in key_d; the backward walk starts with rcon 0x36.
                    state_d = ST_ACTIVE;
                    rc_d    = RC_K10;
                    round_d = ROUND_LAST;
                end else begin
                    state_d = ST_EXPAND;
                end
            end
`endif

            ST_ACTIVE: begin
                if (key_ready_i) begin
                    if (round_q != 4'd0) begin
                        key_d   = inv_key_s;
                        round_d = round_q - 4'd1;
                        rc_d    = rcon_inv_step(rc_q);
                    end else begin
                        // K0 accepted: key_o and round_o hold their last values.
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        key_valid_d = (state_d == ST_ACTIVE);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            key_q       <= {`KEY_WIDTH{1'b0}};
            round_q     <= 4'd0;
            rc_q        <= RC_K10;
            key_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef INV_KEY_FWD_EXPAND_EN
            step_q      <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            round_q     <= round_d;
            rc_q        <= rc_d;
            key_valid_q <= key_valid_d;
            done_q      <= done_d;
`ifdef INV_KEY_FWD_EXPAND_EN
            step_q      <= step_d;
`endif
        end
    end

    assign key_o       = key_q;
    assign round_o     = round_q;
    assign key_valid_o = key_valid_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// -----------------------------------------------------------------------------
// tb_inv_key_schedule
//
// Scoreboard bench for inv_key_schedule. A reference model performs the
// textbook forward AES-128 key expansion on a cipher key and queues the
// expected (round, key) pairs K10..K0; a monitor compares every presented
// key against the head of the queue, popping on each handshake. The external
// S-box is modelled from its GF(2^8) definition.
// -----------------------------------------------------------------------------
module tb_inv_key_schedule;

    logic         clk_i;
    logic         rst_ni;
    logic         start_i;
    logic [127:0] key_i;
    logic [31:0]  w_s_box;
    logic [31:0]  sbox_word_o;
    logic [127:0] key_o;
    logic [3:0]   round_o;
    logic         key_valid_o;
    logic         key_ready_i;
    logic         done_o;

    inv_key_schedule dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .key_i       (key_i),
        .W_S_box     (w_s_box),
        .sbox_word_o (sbox_word_o),
        .key_o       (key_o),
        .round_o     (round_o),
        .key_valid_o (key_valid_o),
        .key_ready_i (key_ready_i),
        .done_o      (done_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]   sbox_tab [0:255];
    logic [127:0] model_rk [0:10];
    logic [131:0] sb_q [$];
    logic         expect_done = 1'b0;
    logic         rand_ready  = 1'b0;

    localparam logic [127:0] FIPS_K0  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] FIPS_K9  = 128'hac7766f3_19fadc21_28d12941_575c006e;
    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;

    assign w_s_box = {sbox_tab[sbox_word_o[31:24]], sbox_tab[sbox_word_o[23:16]],
                      sbox_tab[sbox_word_o[15:8]],  sbox_tab[sbox_word_o[7:0]]};

    task automatic chk(input string name, input logic ok,
                       input logic [131:0] act, input logic [131:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine transform.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gf_mul(inv, x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Forward AES-128 key expansion (44 words) from the cipher key.
    task automatic build_model(input logic [127:0] k0);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]],
                       sbox_tab[tmp[15:8]],  sbox_tab[tmp[7:0]]};
                tmp = tmp ^ {rcon, 24'h000000};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= 10; r++)
            model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Ready driver: constant high or random backpressure.
    initial begin
        key_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            key_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compare every presented key with the scoreboard head.
    initial begin
        logic [131:0] e;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                expect_done = 1'b0;
            end else begin
                if (expect_done) begin
                    chk("done_pulse", done_o === 1'b1 && key_valid_o === 1'b0,
                        {key_valid_o, done_o}, 132'b01);
                    expect_done = 1'b0;
                end else if (done_o) begin
                    chk("spurious_done", 1'b0, 132'(done_o), 132'd0);
                end
                if (key_valid_o) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_valid", 1'b0, 132'(key_valid_o), 132'd0);
                    end else begin
                        e = sb_q[0];
                        chk("key", key_o === e[127:0], 132'(key_o), 132'(e[127:0]));
                        chk("round", round_o === e[131:128], 132'(round_o), 132'(e[131:128]));
                        if (key_ready_i) begin
                            void'(sb_q.pop_front());
                            if (e[131:128] == 4'd0) expect_done = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Launch a run: queue K10..K0, pulse start_i, check start latency.
    task automatic start_run(input logic [127:0] k0);
        logic low_ok;
        build_model(k0);
        for (int r = 10; r >= 0; r--) sb_q.push_back({4'(r), model_rk[r]});
`ifdef INV_KEY_FWD_EXPAND_EN
        key_i = k0;
`else
        key_i = model_rk[10];
`endif
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        key_i   = {$urandom, $urandom, $urandom, $urandom};
`ifdef INV_KEY_FWD_EXPAND_EN
        low_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (key_valid_o) low_ok = 1'b0;
            @(posedge clk_i);
            #1;
        end
        chk("expand_valid_low", low_ok, 132'(low_ok), 132'd1);
`else
        low_ok = 1'b1;
`endif
        chk("start_latency", key_valid_o === 1'b1, 132'(key_valid_o), 132'd1);
        chk("first_key_k10", key_o === model_rk[10], 132'(key_o), 132'(model_rk[10]));
    endtask

    // Wait (bounded) for the done pulse; returns in the done cycle.
    task automatic wait_run_end(input string name);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk_i);
            #1;
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, seen, 132'(seen), 132'd1);
    endtask

    // Wait (bounded) until a given round is presented.
    task automatic wait_round(input logic [3:0] r, input string name);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk_i);
            #1;
            if (key_valid_o && round_o == r) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, seen, 132'(seen), 132'd1);
    endtask

    task automatic check_reset_values(input string name);
        chk(name, key_o === 128'd0 && round_o === 4'd0 && key_valid_o === 1'b0
                  && done_o === 1'b0 && sbox_word_o === 32'd0,
            {key_o, round_o}, 132'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic quiet;
        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
        rst_ni  = 1'b0;
        start_i = 1'b0;
        key_i   = 128'd0;
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_values("reset_in");
        rst_ni = 1'b1;
        quiet = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk_i);
            #1;
            if (key_valid_o !== 1'b0 || done_o !== 1'b0 || key_o !== 128'd0 || round_o !== 4'd0)
                quiet = 1'b0;
        end
        chk("reset_quiet", quiet, 132'(quiet), 132'd1);

        // FIPS-197 vector, ready held high, explicit cycle positions.
        rand_ready = 1'b0;
        @(posedge clk_i);
        #1;
        start_run(FIPS_K0);
        chk("fips_k10", key_o === FIPS_K10 && round_o === 4'd10, {round_o, key_o}, {4'd10, FIPS_K10});
        @(posedge clk_i);
        #1;
        chk("fips_k9", key_o === FIPS_K9 && round_o === 4'd9, {round_o, key_o}, {4'd9, FIPS_K9});
        repeat (9) @(posedge clk_i);
        #1;
        chk("fips_k0", key_o === FIPS_K0 && round_o === 4'd0, {round_o, key_o}, {4'd0, FIPS_K0});
        @(posedge clk_i);
        #1;
        chk("fips_done", done_o === 1'b1 && key_valid_o === 1'b0, {key_valid_o, done_o}, 132'b01);

        // Backpressure on the FIPS vector, then random keys.
        rand_ready = 1'b1;
        start_run(FIPS_K0);
        wait_run_end("bp_fips_end");
        for (int n = 0; n < 4; n++) begin
            start_run({$urandom, $urandom, $urandom, $urandom});
            wait_run_end("rand_run_end");
        end

        // Busy start at round 5 is ignored; restart in the done cycle.
        start_run({$urandom, $urandom, $urandom, $urandom});
        wait_round(4'd5, "busy_round5");
        key_i   = {$urandom, $urandom, $urandom, $urandom};
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        wait_run_end("busy_run_end");
        start_run({$urandom, $urandom, $urandom, $urandom});
        wait_run_end("restart_run_end");

        // Reset abort at round 3, then a normal restart.
        start_run({$urandom, $urandom, $urandom, $urandom});
        wait_round(4'd3, "abort_round3");
        rst_ni = 1'b0;
        sb_q.delete();
        #2;
        check_reset_values("abort_reset_values");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        check_reset_values("abort_after_release");
        repeat (2) @(posedge clk_i);
        #1;
        start_run({$urandom, $urandom, $urandom, $urandom});
        wait_run_end("post_abort_run_end");

        repeat (4) @(posedge clk_i);
        #1;
        chk("scoreboard_empty", sb_q.size() == 0, 132'(sb_q.size()), 132'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/inv_key_schedule.md
# inv_key_schedule

On-the-fly AES-128 inverse key schedule for the decryption datapath. It takes the final round key K10 and walks the schedule backward, producing K10, K9, … K0 one key per handshake. No 10-entry key memory is needed. S-box lookups go through an external shared S-box word port, as in the existing key-expansion blocks. It sits between key load and the inverse-round datapath.

## Interface
- No parameters. Widths come from the codebase defines: `KEY_WIDTH` = 128, `FOUR_BYTE_WIDTH` = 32, `BYTE_WIDTH` = 8.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- start_i  in  1  start a schedule run; sampled only in IDLE.
- key_i  in  128  K10, or the cipher key when INV_KEY_FWD_EXPAND_EN is defined; sampled on the start edge.
- W_S_box  in  32  external S-box result: byte-wise SubWord of sbox_word_o, combinational.
- sbox_word_o  out  32  word sent to the external S-box.
- key_o  out  128  current round key, {w0,w1,w2,w3}, w0 in [127:96].
- round_o  out  4  round index of key_o, 10 down to 0.
- key_valid_o  out  1  key_o is valid.
- key_ready_i  in  1  consumer accepts key_o.
- done_o  out  1  one-cycle pulse after K0 is accepted.

## Operation
- States: IDLE, EXPAND (only when INV_KEY_FWD_EXPAND_EN is defined), ACTIVE.
- IDLE + start_i:
  - Load key_i into the key register.
  - Go to ACTIVE with round_o=10 and rc=8'h36.
  - With the macro: go to EXPAND instead, with rc=8'h01 and the step counter at 0.
- ACTIVE:
  - key_valid_o=1.
  - On key_valid_o && key_ready_i with round_o>0: load the previous key, decrement round_o, step rc.
  - On the handshake with round_o==0: go to IDLE and pulse done_o on the following cycle.
- Inverse step, from current {w0,w1,w2,w3}:
  - t = w3^w2.
  - w3' = t, w2' = w2^w1, w1' = w1^w0.
  - w0' = w0 ^ {W_S_box[23:0],W_S_box[31:24]} ^ {rc,24'h0}.
  - sbox_word_o = t.
- Inverse rcon step: rc <= (rc>>1) ^ (rc[0] ? 8'h8d : 8'h00). Sequence: 36,1b,80,40,20,10,08,04,02,01.
- No handshake: key, round and rc hold. start_i is ignored outside IDLE.
- key_o holds its last value in IDLE.
- round_o never wraps below 0.

## Timing
- Reset values:
  - state=IDLE; key_o=0; round_o=0; key_valid_o=0; done_o=0.
  - sbox_word_o=0, since it derives from the zeroed key register.
  - rc=8'h36.
- Reset asserted mid-run aborts immediately to the reset values. No done_o is produced.
- Start latency: start_i high in cycle n gives key_valid_o high in cycle n+1 with key_o=K10.
- Throughput: one key per cycle while key_ready_i is held high. K10…K0 take 11 consecutive cycles.
- done_o is high exactly one cycle, the cycle after the final handshake. key_valid_o is 0 in that cycle.
- start_i in the same cycle as done_o is accepted, because the state is already IDLE.

## Configuration
- INV_KEY_FWD_EXPAND_EN defined:
  - key_i is the cipher key K0.
  - EXPAND runs 10 forward steps, one per cycle: w0' = w0^SubRot(w3)^{rc,24'h0}, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'. Here sbox_word_o=w3 and rc is stepped forward: rc <= (rc<<1) ^ (rc[7] ? 8'h1b : 8'h00).
  - After the 10th step, enter ACTIVE with rc=8'h36 and round_o=10.
  - key_valid_o rises 11 cycles after start_i.
- Undefined: the EXPAND state and its counter are not built, and key_i must already be K10.

## Test plan
- Reset check: after rst_ni low then high, all outputs are 0 and no key_valid_o appears without start_i.
- FIPS-197 run:
  - Stimulus: key_i = d014f9a8_c9ee2589_e13f0cc8_b6630ca6, key_ready_i=1.
  - Cycle n+1: K10 with round_o=10.
  - Cycle n+2: ac7766f3_19fadc21_28d12941_575c006e with round_o=9.
  - Cycle n+11: 2b7e1516_28aed2a6_abf71588_09cf4f3c with round_o=0.
  - Cycle n+12: done_o.
- Backpressure: key_ready_i toggled randomly. Keys and round_o hold while stalled and the sequence is identical to the FIPS-197 run.
- Busy start: start_i pulsed at round_o=5 is ignored. A new start_i during the done_o cycle is accepted and K10 reappears the next cycle.
- Reset abort: rst_ni pulsed at round_o=3 returns everything to the reset values. A restart then completes normally.
- With INV_KEY_FWD_EXPAND_EN: key_i=2b7e1516_28aed2a6_abf71588_09cf4f3c. key_valid_o rises 11 cycles after start_i with key_o = d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
